// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
//
// SPI write initiator for the register-configuration interface. Accepts a
// register write over a valid/ready handshake and serializes it as a 16-bit
// mode-0 frame {1'b1 (write), addr[6:0], data[7:0]} on SCLK/nCS/COPI, MSB first.
// SCLK and nCS timing is stretched over several clk cycles because the
// peripheral samples these pins through 2-flop synchronizers.
//
// Parameters:
//   HALF_PERIOD  clk cycles per SCLK half-period (>= 2)
//   CS_HOLD      clk cycles nCS stays low after the last SCLK fall (>= 4)
//   CS_IDLE      clk cycles nCS stays high between frames (>= 1)
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   req_valid/ready     request handshake; ready only while IDLE
//   req_addr, req_data  7-bit register address, 8-bit write data
//   SCLK, nCS, COPI     SPI pins, all registered
//   busy                high whenever the controller is not IDLE
//   done                one-cycle pulse when nCS rises at the end of a frame
//   err                 one-cycle pulse on a rejected request
//
// Optional feature (macro SPI_CTRL_ADDR_CHECK_EN): requests with
// req_addr > 7'h04 are accepted but not transmitted, and err pulses instead.
// Without the macro every address is sent and err is tied to 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_controller #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_HOLD     = 8,
  parameter int CS_IDLE     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // One counter serves as SCLK divider in SHIFT and as the HOLD/GAP timer.
  localparam int MAX_A = (HALF_PERIOD > CS_HOLD) ? HALF_PERIOD : CS_HOLD;
  localparam int MAX_C = (MAX_A > CS_IDLE) ? MAX_A : CS_IDLE;
  localparam int CW    = $clog2(MAX_C);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t        state;
  logic [14:0]   shreg;     // remaining frame bits; bit 15 goes straight to COPI
  logic [CW-1:0] cnt;
  logic [4:0]    rise_cnt;  // SCLK rising edges seen in this frame, 0..16
  logic          accept;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;

`ifdef SPI_CTRL_ADDR_CHECK_EN
  logic err_q;
  logic addr_bad;
  assign addr_bad = (req_addr > 7'h04);
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register
  // in this block sees the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      rise_cnt <= '0;
      SCLK     <= 1'b0;
      nCS      <= 1'b1;
      COPI     <= 1'b0;
      done     <= 1'b0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised only on
      // the cycle that generates them.
      done <= 1'b0;
`ifdef SPI_CTRL_ADDR_CHECK_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef SPI_CTRL_ADDR_CHECK_EN
          // Out-of-range request: consume it, stay idle, flag it.
          if (accept && addr_bad) err_q <= 1'b1;
          else
`endif
          if (accept) begin
            state    <= SHIFT;
            shreg    <= {req_addr, req_data};
            COPI     <= 1'b1;            // frame bit 15: write flag
            nCS      <= 1'b0;
            SCLK     <= 1'b0;
            cnt      <= '0;
            rise_cnt <= '0;
          end
        end

        SHIFT: begin
          if (cnt == CW'(HALF_PERIOD - 1)) begin
            cnt  <= '0;
            SCLK <= ~SCLK;
            if (!SCLK) begin
              rise_cnt <= rise_cnt + 5'd1;
            end else if (rise_cnt == 5'd16) begin
              // 16th fall: COPI keeps bit 0, counter restarts as hold timer.
              state <= HOLD;
            end else begin
              COPI  <= shreg[14];
              shreg <= {shreg[13:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (cnt == CW'(CS_HOLD - 1)) begin
            cnt   <= '0;
            state <= GAP;
            nCS   <= 1'b1;
            COPI  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          if (cnt == CW'(CS_IDLE - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
//
// Self-checking bench for spi_controller. Two instances share clk/rst: one with
// default parameters and one with HALF_PERIOD=2, CS_HOLD=4, CS_IDLE=1. A
// behavioural model derives each expected frame word and every expected event
// time (SCLK rises, nCS low span, done, ready return) from the accept cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_a, valid_f;
  logic [6:0] req_addr;
  logic [7:0] req_data;

  logic a_ready, a_sclk, a_ncs, a_copi, a_busy, a_done, a_err;
  logic f_ready, f_sclk, f_ncs, f_copi, f_busy, f_done, f_err;

  always #5 clk = ~clk;

  spi_controller dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(a_ready),
    .req_addr(req_addr), .req_data(req_data),
    .SCLK(a_sclk), .nCS(a_ncs), .COPI(a_copi),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  spi_controller #(.HALF_PERIOD(2), .CS_HOLD(4), .CS_IDLE(1)) dut_f (
    .clk(clk), .rst(rst), .req_valid(valid_f), .req_ready(f_ready),
    .req_addr(req_addr), .req_data(req_data),
    .SCLK(f_sclk), .nCS(f_ncs), .COPI(f_copi),
    .busy(f_busy), .done(f_done), .err(f_err)
  );

  // Observation port: selects which instance the frame monitor watches.
  bit   sel;
  logic m_ready, m_sclk, m_ncs, m_copi, m_busy, m_done, m_err;
  assign m_ready = sel ? f_ready : a_ready;
  assign m_sclk  = sel ? f_sclk  : a_sclk;
  assign m_ncs   = sel ? f_ncs   : a_ncs;
  assign m_copi  = sel ? f_copi  : a_copi;
  assign m_busy  = sel ? f_busy  : a_busy;
  assign m_done  = sel ? f_done  : a_done;
  assign m_err   = sel ? f_err   : a_err;

  int checks = 0;
  int errors = 0;

  task automatic set_valid(input bit fast, input logic v);
    if (fast) valid_f = v; else valid_a = v;
  endtask

  // Sends one request on the selected instance and checks the whole frame
  // against the model. Called at a negedge. abort_rise > 0 asserts rst right
  // after that many SCLK rises and checks the abort instead.
  task automatic send_frame(input bit fast, input logic [6:0] addr,
                            input logic [7:0] data, input bit keep_valid,
                            input bit poke_busy, input int abort_rise,
                            input string name);
    int h, hold, idle;
    logic [15:0] exp_word, got_word;
    int r, bad_rise, ncs_low, dones, done_at, ready_at, ncs_rise_at, n;
    int late_done, late_ncs;
    bit prev_sclk;
    h    = fast ? 2 : 4;
    hold = fast ? 4 : 8;
    idle = fast ? 1 : 4;
    exp_word = {1'b1, addr, data};
    got_word = '0;
    r = 0; bad_rise = 0; ncs_low = 0; dones = 0;
    done_at = -1; ready_at = -1; ncs_rise_at = -1;
    prev_sclk = 1'b0;
    sel = fast;

    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b expected 1", name, m_ready);
    end
    req_addr = addr;
    req_data = data;
    set_valid(fast, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) set_valid(fast, 1'b0);

    checks++;
    if ({m_ncs, m_copi} !== 2'b01) begin
      errors++;
      $display("FAIL %s first_cycle ncs/copi: got %b expected 01", name, {m_ncs, m_copi});
    end

    n = 1;
    while (ready_at < 0 && n <= 2000) begin
      if (n > 1) @(negedge clk);
      if (m_sclk && !prev_sclk) begin
        if (r < 16) got_word[15 - r] = m_copi;
        if (n != 1 + h + 2 * h * r) bad_rise++;
        r++;
        if (abort_rise > 0 && r == abort_rise) begin
          rst = 1'b1;
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          checks++;
          if ({m_sclk, m_ncs, m_copi, m_ready, m_busy, m_done, m_err} !== 7'b0101000) begin
            errors++;
            $display("FAIL %s abort_outputs sclk,ncs,copi,ready,busy,done,err: got %b expected 0101000",
                     name, {m_sclk, m_ncs, m_copi, m_ready, m_busy, m_done, m_err});
          end
          late_done = 0; late_ncs = 0;
          for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_done) late_done++;
            if (!m_ncs) late_ncs++;
          end
          checks++;
          if (late_done != 0 || late_ncs != 0) begin
            errors++;
            $display("FAIL %s after_abort done/ncs_low cycles: got %0d/%0d expected 0/0",
                     name, late_done, late_ncs);
          end
          return;
        end
      end
      prev_sclk = m_sclk;
      if (!m_ncs) ncs_low++;
      else if (ncs_rise_at < 0) ncs_rise_at = n;
      if (m_done) begin dones++; done_at = n; end
      if (m_ready) ready_at = n;
      if (poke_busy && n == 40) begin
        req_addr = ~addr;
        req_data = ~data;
        set_valid(fast, 1'b1);
      end
      if (poke_busy && n == 41) set_valid(fast, 1'b0);
      n++;
    end

    checks++;
    if (ready_at < 0) begin
      errors++;
      $display("FAIL %s timeout: ready never returned within 2000 cycles", name);
      return;
    end
    checks++;
    if (r != 16) begin
      errors++;
      $display("FAIL %s sclk_rises: got %0d expected 16", name, r);
    end
    checks++;
    if (got_word !== exp_word) begin
      errors++;
      $display("FAIL %s frame: got %h expected %h", name, got_word, exp_word);
    end
    checks++;
    if (bad_rise != 0) begin
      errors++;
      $display("FAIL %s rise_timing: got %0d misplaced rises expected 0", name, bad_rise);
    end
    checks++;
    if (ncs_low != 32 * h + hold) begin
      errors++;
      $display("FAIL %s ncs_low_cycles: got %0d expected %0d", name, ncs_low, 32 * h + hold);
    end
    checks++;
    if (dones != 1 || done_at != 1 + 32 * h + hold) begin
      errors++;
      $display("FAIL %s done: got %0d pulses at %0d expected 1 at %0d",
               name, dones, done_at, 1 + 32 * h + hold);
    end
    checks++;
    if (ncs_rise_at != 1 + 32 * h + hold) begin
      errors++;
      $display("FAIL %s ncs_rise: got %0d expected %0d", name, ncs_rise_at, 1 + 32 * h + hold);
    end
    checks++;
    if (ready_at != 1 + 32 * h + hold + idle) begin
      errors++;
      $display("FAIL %s ready_return: got %0d expected %0d",
               name, ready_at, 1 + 32 * h + hold + idle);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_a = 1'b0; valid_f = 1'b0;
    req_addr = '0; req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_sclk, a_ncs, a_copi, a_ready, a_busy, a_done, a_err} !== 7'b0101000) begin
      errors++;
      $display("FAIL reset_a sclk,ncs,copi,ready,busy,done,err: got %b expected 0101000",
               {a_sclk, a_ncs, a_copi, a_ready, a_busy, a_done, a_err});
    end
    checks++;
    if ({f_sclk, f_ncs, f_copi, f_ready, f_busy, f_done, f_err} !== 7'b0101000) begin
      errors++;
      $display("FAIL reset_f sclk,ncs,copi,ready,busy,done,err: got %b expected 0101000",
               {f_sclk, f_ncs, f_copi, f_ready, f_busy, f_done, f_err});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    send_frame(1'b0, 7'h04, 8'hA5, 1'b0, 1'b0, 0, "single");
  endtask

  task automatic test_back_to_back();
    send_frame(1'b0, 7'h00, 8'hFF, 1'b1, 1'b0, 0, "b2b_first");
    send_frame(1'b0, 7'h01, 8'h0F, 1'b0, 1'b0, 0, "b2b_second");
  endtask

  task automatic test_busy_request();
    int extra_low;
    send_frame(1'b0, 7'h03, 8'h5A, 1'b0, 1'b1, 0, "busy_req");
    extra_low = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!a_ncs) extra_low++;
    end
    checks++;
    if (extra_low != 0) begin
      errors++;
      $display("FAIL busy_req extra_frame ncs_low cycles: got %0d expected 0", extra_low);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(1'b0, 7'h01, 8'hC3, 1'b0, 1'b0, 7, "abort");
    send_frame(1'b0, 7'h02, 8'h3C, 1'b0, 1'b0, 0, "after_abort");
  endtask

  task automatic test_param_sweep();
    send_frame(1'b1, 7'h03, 8'h81, 1'b0, 1'b0, 0, "sweep");
  endtask

  task automatic test_addr_check();
`ifdef SPI_CTRL_ADDR_CHECK_EN
    int errs, lows, dns;
    sel = 1'b0;
    req_addr = 7'h05; req_data = 8'h12; valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    checks++;
    if ({a_err, a_ready, a_ncs, a_done} !== 4'b1110) begin
      errors++;
      $display("FAIL addr_check err,ready,ncs,done at T+1: got %b expected 1110",
               {a_err, a_ready, a_ncs, a_done});
    end
    errs = 0; lows = 0; dns = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_err) errs++;
      if (!a_ncs) lows++;
      if (a_done) dns++;
    end
    checks++;
    if (errs != 0 || lows != 0 || dns != 0) begin
      errors++;
      $display("FAIL addr_check after err/ncs_low/done: got %0d/%0d/%0d expected 0/0/0",
               errs, lows, dns);
    end
`else
    send_frame(1'b0, 7'h05, 8'h12, 1'b0, 1'b0, 0, "addr_unchecked");
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      send_frame(1'($urandom_range(0, 1)), 7'($urandom_range(0, 4)),
                 8'($urandom), 1'b0, 1'b0, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_busy_request();
    test_reset_mid_frame();
    test_param_sweep();
    test_addr_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
